// File: rtl/hex_refresh_ctrl.sv
// Nibble store and refresh sequencer for active-low 7-seg displays sharing one external decoder.
// Optional blink gating is compiled in with HEX_BLINK_EN.
module hex_refresh_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [7:0]              wr_byte,
   input  logic                    clr,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              dec_nibble,
   input  logic [6:0]              dec_seg,
`ifdef HEX_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || BLINK_DIV < 1) begin : g_param_check
      $error("hex_refresh_ctrl: NUM_DIGITS must be even and >=2, BLINK_DIV >=1");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LATCH} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [IW-1:0]         r_idx;
   logic [3:0]            r_digit [NUM_DIGITS];
   logic [6:0]            r_seg   [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_blank;
   logic [3:0]            r_nibble;
   logic                  w_accept;
   logic                  w_blank_chg;

   assign w_accept    = wr_valid && wr_ready;
   assign w_blank_chg = (blank_mask != r_blank);
   assign dec_nibble  = r_nibble;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (clr) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept || w_blank_chg) w_next = S_LOAD;
            S_LOAD:  w_next = S_LATCH;
            S_LATCH: w_next = (r_idx == LAST_IDX) ? S_IDLE : S_LOAD;
            default: w_next = S_LOAD;
         endcase
      end
   end

   // rst gates ready so no byte is consumed while the block is being reset
   always_comb begin
      wr_ready = (r_state == S_IDLE) && !clr && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_blank  <= '0;
         r_nibble <= '0;
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            r_digit[k] <= '0;
            r_seg[k]   <= '1;
         end
      end else if (clr) begin
         r_idx <= '0;
         for (int unsigned k = 0; k < NUM_DIGITS; k++) r_digit[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_idx <= '0;
               if (w_accept) begin
                  for (int unsigned k = 2; k < NUM_DIGITS; k++) r_digit[k] <= r_digit[k-2];
                  r_digit[1] <= wr_byte[7:4];
                  r_digit[0] <= wr_byte[3:0];
               end
            end
            S_LOAD: r_nibble <= r_digit[r_idx];
            S_LATCH: begin
               r_seg[r_idx] <= blank_mask[r_idx] ? 7'h7F : dec_seg;
               r_blank      <= blank_mask;
               if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end
            default: r_idx <= '0;
         endcase
      end
   end

`ifdef HEX_BLINK_EN
   logic [31:0] r_blink_cnt;
   logic        r_phase_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_phase_on  <= 1'b1;
      end else if (r_blink_cnt == 32'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase_on  <= ~r_phase_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 32'd1;
      end
   end
`endif

   always_comb begin
      hex_out = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         hex_out[7*k +: 7] = r_seg[k];
`ifdef HEX_BLINK_EN
         if (!r_phase_on && blink_mask[k]) hex_out[7*k +: 7] = 7'h7F;
`endif
      end
   end

endmodule

// File: tb/tb_hex_refresh_ctrl.sv
// Bench for hex_refresh_ctrl: digit store modelled as a shift array, compared after each refresh pass.
// Blink checks are compiled when HEX_BLINK_EN is defined.
module tb_hex_refresh_ctrl;

   localparam int N  = 6;
   localparam int BD = 4;
   localparam int PASS_LAT = 2*N + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [7:0]     wr_byte = '0;
   logic           clr = 1'b0;
   logic [N-1:0]   blank_mask = '0;
   logic [3:0]     dec_nibble;
   logic [6:0]     dec_seg;
   logic [7*N-1:0] hex_out;
`ifdef HEX_BLINK_EN
   logic [N-1:0]   blink_mask = '0;
`endif

   int checks = 0;
   int errors = 0;
   logic [3:0] m_digit [N];

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
      endcase
   endfunction

   // shared board decoder
   assign dec_seg = seg7(dec_nibble);

   hex_refresh_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_byte    (wr_byte),
      .clr        (clr),
      .blank_mask (blank_mask),
      .dec_nibble (dec_nibble),
      .dec_seg    (dec_seg),
`ifdef HEX_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .hex_out    (hex_out)
   );

   function automatic logic [7*N-1:0] model_hex();
      logic [7*N-1:0] h;
      for (int k = 0; k < N; k++) h[7*k +: 7] = blank_mask[k] ? 7'h7F : seg7(m_digit[k]);
      return h;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic m_write(input logic [7:0] b);
      for (int k = N-1; k >= 2; k--) m_digit[k] = m_digit[k-2];
      m_digit[1] = b[7:4];
      m_digit[0] = b[3:0];
   endtask

   task automatic m_clear();
      for (int k = 0; k < N; k++) m_digit[k] = 4'h0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!wr_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!wr_ready) check("ready_timeout", wr_ready, 1);
   endtask

   // called one cycle after the triggering cycle; checks pass latency and final display
   task automatic finish_pass(input string tag);
      int c;
      check({tag, "_busy"}, wr_ready, 0);
      wait_ready(c);
      check({tag, "_latency"}, c + 1, PASS_LAT);
      check({tag, "_hex"}, hex_out, model_hex());
   endtask

   task automatic do_write(input logic [7:0] b);
      int c;
      wr_valid = 1'b1;
      wr_byte  = b;
      wait_ready(c);
      m_write(b);
      @(negedge clk);
      wr_valid = 1'b0;
      finish_pass("write");
   endtask

   task automatic do_blank(input logic [N-1:0] m);
      int c;
      wait_ready(c);
      blank_mask = m;
      @(negedge clk);
      finish_pass("blank");
   endtask

   task automatic do_clr_idle();
      int c;
      wait_ready(c);
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_byte  = 8'($urandom_range(1, 255));
      #1;
      check("clr_blocks_ready", wr_ready, 0);
      m_clear();
      @(negedge clk);
      clr      = 1'b0;
      wr_valid = 1'b0;
      finish_pass("clr_idle");
   endtask

   initial begin
      int c, hs, f;
      logic took;
      logic [6:0] samp [24];
      m_clear();

      // reset
      repeat (3) @(negedge clk);
      check("rst_hex", hex_out, {7*N{1'b1}});
      check("rst_ready", wr_ready, 0);
      check("rst_nibble", dec_nibble, 0);
      rst = 1'b0;
      wait_ready(c);
      check("rst_ready_cycle", c, 2*N);
      check("rst_hex_zero", hex_out, model_hex());

      // two fixed writes
      do_write(8'hA5);
      check("a5_digits", hex_out[13:0], {7'h08, 7'h12});
      do_write(8'h31);
      check("a5_31_digits", hex_out[27:0], {7'h08, 7'h12, 7'h30, 7'h79});
      check("a5_31_upper", hex_out[41:28], {7'h40, 7'h40});

      // blank digit1 then unblank
      do_blank(6'b000010);
      check("blank_d1", hex_out[13:7], 7'h7F);
      do_blank('0);

      // wr_valid held across passes: one shift per handshake
      wait_ready(c);
      hs = 0;
      wr_valid = 1'b1;
      wr_byte  = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         took = wr_ready;
         if (took) begin
            m_write(wr_byte);
            hs++;
         end
         @(negedge clk);
         if (took) wr_byte = 8'($urandom);
      end
      wr_valid = 1'b0;
      wait_ready(c);
      check("hold_handshakes", hs, 4);
      check("hold_hex", hex_out, model_hex());

      // clr while loading idx 3 of a pass
      wr_valid = 1'b1;
      wr_byte  = 8'hFF;
      wait_ready(c);
      m_write(8'hFF);
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (6) @(negedge clk);
      clr = 1'b1;
      m_clear();
      @(negedge clk);
      clr = 1'b0;
      check("clr_keep_d0", hex_out[6:0], 7'h0E);
      finish_pass("clr_mid");

      do_clr_idle();

      // randomized mix
      for (int i = 0; i < 25; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)      do_write(8'($urandom));
         else if (r <= 7) do_blank(blank_mask ^ N'($urandom_range(1, (1 << N) - 1)));
         else             do_clr_idle();
      end
      if (blank_mask != '0) do_blank('0);

`ifdef HEX_BLINK_EN
      blink_mask = 6'b000001;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         samp[i] = hex_out[6:0];
         check("blink_steady", hex_out[7*N-1:7], model_hex() >> 7);
      end
      f = 0;
      for (int i = 8; i >= 1; i--) if (samp[i] != samp[i-1]) f = i;
      if (f == 0) begin
         check("blink_toggle", 0, 1);
      end else begin
         check("blink_vals", (samp[f] == 7'h7F) ? samp[f-1] : samp[f], seg7(m_digit[0]));
         check("blink_off", (samp[f] == 7'h7F) || (samp[f-1] == 7'h7F), 1);
         for (int i = f; i < 24; i++)
            check("blink_phase", samp[i], (((i - f) / BD) % 2 == 0) ? samp[f] : samp[f-1]);
      end
      blink_mask = '0;
`endif

      // reset in the middle of a pass
      wr_valid = 1'b1;
      wr_byte  = 8'($urandom);
      wait_ready(c);
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_hex", hex_out, {7*N{1'b1}});
      check("midrst_ready", wr_ready, 0);
      check("midrst_nibble", dec_nibble, 0);
      rst = 1'b0;
      m_clear();
      wait_ready(c);
      check("midrst_ready_cycle", c, 2*N);
      check("midrst_hex_zero", hex_out, model_hex());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
